// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store front end with read-modify-write for sub-word stores
module mem_access_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_ADDR_BITS = 9
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [MEM_ADDR_BITS+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_error,
  output logic                     mem_enable,
  output logic                     mem_write_enable,
  output logic [MEM_ADDR_BITS-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RDW, S_WR, S_RESP} state_t;

  state_t                   state, state_nx;
  logic                     cap_write;
  logic [1:0]               cap_size;
  logic                     cap_unsigned;
  logic [MEM_ADDR_BITS+1:0] cap_addr;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic                     error_q;

  logic                     accept;
  logic                     req_bad;
  logic [7:0]               sel_byte;
  logic [15:0]              sel_half;
  logic [DATA_WIDTH-1:0]    load_ext;
  logic [DATA_WIDTH-1:0]    merged;

  assign accept = req_valid && (state == S_IDLE);

  // Reject illegal sizes and misaligned halfword/word accesses before touching the RAM
  always_comb begin
    req_bad = 1'b0;
    if (req_size == 2'b11)                             req_bad = 1'b1;
    else if (req_size == SZ_HALF && req_addr[0])       req_bad = 1'b1;
    else if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) req_bad = 1'b1;
  end

  // Lane select and extension for loads, lane merge for sub-word stores
  always_comb begin
    case (cap_addr[1:0])
      2'd0:    sel_byte = mem_rdata[7:0];
      2'd1:    sel_byte = mem_rdata[15:8];
      2'd2:    sel_byte = mem_rdata[23:16];
      default: sel_byte = mem_rdata[31:24];
    endcase
    sel_half = cap_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (cap_size)
      SZ_BYTE: load_ext = {{(DATA_WIDTH-8){~cap_unsigned & sel_byte[7]}}, sel_byte};
      SZ_HALF: load_ext = {{(DATA_WIDTH-16){~cap_unsigned & sel_half[15]}}, sel_half};
      default: load_ext = mem_rdata;
    endcase

    merged = mem_rdata;
    if (cap_size == SZ_BYTE)
      merged[{cap_addr[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{cap_addr[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state: word stores skip the read, everything sub-word or a load reads first
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_bad)                               state_nx = S_RESP;
          else if (req_write && req_size == SZ_WORD) state_nx = S_WR;
          else                                       state_nx = S_RD;
        end
      end
      S_RD:    state_nx = S_RDW;
      S_RDW:   state_nx = cap_write ? S_WR : S_RESP;
      S_WR:    state_nx = S_RESP;
      S_RESP:  if (resp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs decoded from state; write data only presented during the write cycle
  always_comb begin
    req_ready        = (state == S_IDLE);
    resp_valid       = (state == S_RESP);
    mem_enable       = (state == S_RD) || (state == S_WR);
    mem_write_enable = (state == S_WR);
    mem_wdata        = (state == S_WR) ? wdata_q : '0;
  end

  // Request capture on accept; RDW folds the RAM word into load data or the merged store word
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cap_write    <= 1'b0;
      cap_size     <= 2'b00;
      cap_unsigned <= 1'b0;
      cap_addr     <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      error_q      <= 1'b0;
    end else if (accept) begin
      cap_write    <= req_write;
      cap_size     <= req_size;
      cap_unsigned <= req_unsigned;
      cap_addr     <= req_addr;
      wdata_q      <= req_wdata;
      rdata_q      <= '0;
      error_q      <= req_bad;
    end else if (state == S_RDW) begin
      if (cap_write) wdata_q <= merged;
      else           rdata_q <= load_ext;
    end
  end

  assign mem_address = cap_addr[MEM_ADDR_BITS+1:2];
  assign resp_rdata  = rdata_q;
  assign resp_error  = error_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed table-driven bench for mem_access_ctrl
module tb_mem_access_ctrl;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [10:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_enable;
  logic        mem_write_enable;
  logic [8:0]  mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_access_ctrl #(.DATA_WIDTH(32), .MEM_ADDR_BITS(9)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error), .mem_enable(mem_enable),
    .mem_write_enable(mem_write_enable), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Block RAM model: registered read, read-before-write, plus a bench-side preload port
  logic [31:0] ram [0:511];
  logic        bd_we = 1'b0;
  logic [8:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;
  always @(posedge clock) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_enable) begin
      mem_rdata <= ram[mem_address];
      if (mem_write_enable) ram[mem_address] <= mem_wdata;
    end
  end

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_en;
    int          exp_wr;
    int          exp_wr_at;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs [21];

  function automatic vec_t v(logic wr, logic [1:0] sz, logic uns, logic [10:0] addr,
                             logic [31:0] wdata, logic [31:0] exp_rdata, logic exp_err,
                             int lat, int en, int wrc, int wr_at, logic [31:0] word);
    vec_t r;
    r.wr = wr; r.sz = sz; r.uns = uns; r.addr = addr; r.wdata = wdata;
    r.exp_rdata = exp_rdata; r.exp_err = exp_err; r.exp_lat = lat;
    r.exp_en = en; r.exp_wr = wrc; r.exp_wr_at = wr_at; r.exp_word = word;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clock);
    @(negedge clock);
    bd_we = 1'b0;
  endtask

  task automatic scramble_req();
    req_write    = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = 11'($urandom);
    req_wdata    = $urandom;
  endtask

  // Issue one request from a negedge in IDLE and check its whole transaction
  task automatic do_vec(input vec_t t, input int idx);
    int lat, en, wrc, wr_at;
    check($sformatf("v%0d ready_idle", idx), 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = t.wr; req_size = t.sz; req_unsigned = t.uns;
    req_addr = t.addr; req_wdata = t.wdata;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    scramble_req();
    lat = 0; en = 0; wrc = 0; wr_at = 0;
    for (int k = 1; k <= 20; k++) begin
      if (mem_enable) en++;
      if (mem_write_enable) begin wrc++; wr_at = k; end
      if (resp_valid) begin lat = k; break; end
      @(negedge clock);
    end
    check($sformatf("v%0d latency", idx), 32'(lat), 32'(t.exp_lat));
    check($sformatf("v%0d rdata", idx), resp_rdata, t.exp_rdata);
    check($sformatf("v%0d error", idx), 32'(resp_error), 32'(t.exp_err));
    check($sformatf("v%0d enables", idx), 32'(en), 32'(t.exp_en));
    check($sformatf("v%0d writes", idx), 32'(wrc), 32'(t.exp_wr));
    check($sformatf("v%0d write_cycle", idx), 32'(wr_at), 32'(t.exp_wr_at));
    check($sformatf("v%0d ready_in_resp", idx), 32'(req_ready), 32'd0);
    resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready = 1'b0;
    check($sformatf("v%0d resp_dropped", idx), 32'(resp_valid), 32'd0);
    check($sformatf("v%0d ram_word", idx), ram[t.addr[10:2]], t.exp_word);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, " resp_error"}, 32'(resp_error), 32'd0);
    check({tag, " resp_rdata"}, resp_rdata, 32'd0);
    check({tag, " mem_enable"}, 32'(mem_enable), 32'd0);
    check({tag, " mem_we"}, 32'(mem_write_enable), 32'd0);
    check({tag, " mem_address"}, 32'(mem_address), 32'd0);
    check({tag, " mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    for (int i = 0; i < 512; i++) ram[i] = 32'h0;
    vecs[0]  = v(1, 2'b10, 0, 11'h010, 32'hDEADBEEF, 32'h0,        0, 2, 1, 1, 1, 32'hDEADBEEF);
    vecs[1]  = v(0, 2'b10, 0, 11'h010, 32'h0,        32'hDEADBEEF, 0, 3, 1, 0, 0, 32'hDEADBEEF);
    vecs[2]  = v(1, 2'b00, 0, 11'h022, 32'h123456AA, 32'h0,        0, 4, 2, 1, 3, 32'h11AA3344);
    vecs[3]  = v(1, 2'b10, 0, 11'h020, 32'h80FF0000, 32'h0,        0, 2, 1, 1, 1, 32'h80FF0000);
    vecs[4]  = v(0, 2'b00, 0, 11'h023, 32'h0,        32'hFFFFFF80, 0, 3, 1, 0, 0, 32'h80FF0000);
    vecs[5]  = v(0, 2'b00, 1, 11'h023, 32'h0,        32'h00000080, 0, 3, 1, 0, 0, 32'h80FF0000);
    vecs[6]  = v(0, 2'b01, 0, 11'h022, 32'h0,        32'hFFFF80FF, 0, 3, 1, 0, 0, 32'h80FF0000);
    vecs[7]  = v(0, 2'b01, 1, 11'h022, 32'h0,        32'h000080FF, 0, 3, 1, 0, 0, 32'h80FF0000);
    vecs[8]  = v(1, 2'b01, 0, 11'h022, 32'hFFFF1234, 32'h0,        0, 4, 2, 1, 3, 32'h12340000);
    vecs[9]  = v(0, 2'b10, 0, 11'h020, 32'h0,        32'h12340000, 0, 3, 1, 0, 0, 32'h12340000);
    vecs[10] = v(0, 2'b01, 0, 11'h001, 32'h0,        32'h0,        1, 1, 0, 0, 0, 32'h0);
    vecs[11] = v(1, 2'b10, 0, 11'h002, 32'h55555555, 32'h0,        1, 1, 0, 0, 0, 32'h0);
    vecs[12] = v(0, 2'b11, 0, 11'h004, 32'h0,        32'h0,        1, 1, 0, 0, 0, 32'h0);
    vecs[13] = v(1, 2'b11, 0, 11'h010, 32'h0,        32'h0,        1, 1, 0, 0, 0, 32'hDEADBEEF);
    vecs[14] = v(0, 2'b00, 0, 11'h011, 32'h0,        32'hFFFFFFBE, 0, 3, 1, 0, 0, 32'hDEADBEEF);
    vecs[15] = v(0, 2'b00, 1, 11'h012, 32'h0,        32'h000000AD, 0, 3, 1, 0, 0, 32'hDEADBEEF);
    vecs[16] = v(1, 2'b00, 0, 11'h013, 32'h00000077, 32'h0,        0, 4, 2, 1, 3, 32'h77ADBEEF);
    vecs[17] = v(0, 2'b01, 0, 11'h010, 32'h0,        32'hFFFFBEEF, 0, 3, 1, 0, 0, 32'h77ADBEEF);
    vecs[18] = v(0, 2'b00, 0, 11'h010, 32'h0,        32'hFFFFFFEF, 0, 3, 1, 0, 0, 32'h77ADBEEF);
    vecs[19] = v(1, 2'b01, 0, 11'h010, 32'hAAAA0102, 32'h0,        0, 4, 2, 1, 3, 32'h77AD0102);
    vecs[20] = v(0, 2'b10, 1, 11'h010, 32'h0,        32'h77AD0102, 0, 3, 1, 0, 0, 32'h77AD0102);

    reset_n = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("reset ready", 32'(req_ready), 32'd1);
    preload(9'h008, 32'h11223344);

    for (int i = 0; i < 21; i++) do_vec(vecs[i], i);

    // Back-pressure: response held for 5 cycles while another request waits
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 11'h010; req_wdata = '0;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin @(negedge clock); n++; end
    check("bp resp_seen", 32'(resp_valid), 32'd1);
    check("bp first_rdata", resp_rdata, 32'h77AD0102);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 11'h040; req_wdata = 32'hCAFEF00D;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check($sformatf("bp%0d resp_valid", c), 32'(resp_valid), 32'd1);
      check($sformatf("bp%0d rdata", c), resp_rdata, 32'h77AD0102);
      check($sformatf("bp%0d error", c), 32'(resp_error), 32'd0);
      check($sformatf("bp%0d req_ready", c), 32'(req_ready), 32'd0);
      check($sformatf("bp%0d mem_enable", c), 32'(mem_enable), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready = 1'b0;
    check("bp release resp_valid", 32'(resp_valid), 32'd0);
    check("bp release req_ready", 32'(req_ready), 32'd1);
    check("bp release mem_enable", 32'(mem_enable), 32'd0);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    check("bp store we", 32'(mem_write_enable), 32'd1);
    check("bp store wdata", mem_wdata, 32'hCAFEF00D);
    check("bp store address", 32'(mem_address), 32'h010);
    @(negedge clock);
    check("bp store resp", 32'(resp_valid), 32'd1);
    resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready = 1'b0;
    check("bp store ram", ram[9'h010], 32'hCAFEF00D);

    // Reset during RDW of a byte store: no write may land
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 11'h013; req_wdata = 32'h00000011;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    check("rst rd enable", 32'(mem_enable), 32'd1);
    @(negedge clock);
    check("rst rdw enable", 32'(mem_enable), 32'd0);
    reset_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    @(posedge clock);
    @(negedge clock);
    check_reset_outputs("rst_held");
    reset_n = 1'b1;
    @(negedge clock);
    check("rst ram unchanged", ram[9'h004], 32'h77AD0102);
    do_vec(v(0, 2'b10, 0, 11'h010, 32'h0, 32'h77AD0102, 0, 3, 1, 0, 0, 32'h77AD0102), 99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
